rf_dump_sequencer: RTL and testbench
====================================

// Module: rf_dump_sequencer
// PURPOSE
//   Shares the CPU register file's read and write ports between the single-cycle CPU datapath and a debug dump engine.
//   On dbg_start_i it stalls the CPU and reads r0..r(DUMP_COUNT-1) in order.
//   Each word goes out on a valid/ready stream, then the CPU is released.
//   Sits between the CPU core and the register file; replaces hierarchical peeking at register contents.
// PARAMETERS
//   DATA_W      32  register width
//   ADDR_W      5   register address width
//   DUMP_COUNT  13  registers dumped, from r0 up; legal range 1..2**ADDR_W
// PORTS
//   clk_i          in   1       clock, rising edge
//   rst_i          in   1       reset, asynchronous, active-high
//   cpu_raddr_i    in   ADDR_W  CPU read address (shared read port)
//   cpu_we_i       in   1       CPU write enable
//   cpu_waddr_i    in   ADDR_W  CPU write address
//   cpu_wdata_i    in   DATA_W  CPU write data
//   cpu_stall_o    out  1       CPU must hold its PC and state while high
//   rf_raddr_o     out  ADDR_W  to register file read address
//   rf_rdata_i     in   DATA_W  from register file, combinational read
//   rf_we_o        out  1       to register file write enable
//   rf_waddr_o     out  ADDR_W  to register file write address
//   rf_wdata_o     out  DATA_W  to register file write data
//   dbg_start_i    in   1       1-cycle request to start a dump
//   dump_valid_o   out  1       dump_addr_o/dump_data_o are valid
//   dump_ready_i   in   1       consumer accepts the word
//   dump_addr_o    out  ADDR_W  index of the word being presented
//   dump_data_o    out  DATA_W  register contents
//   dump_done_o    out  1       1-cycle pulse after the last word is accepted
// BEHAVIOUR
//   Reset values: state IDLE, idx 0, cpu_stall_o 0, dump_valid_o 0, dump_done_o 0, dump_addr_o 0, dump_data_o 0.
//   Mid-dump reset aborts at once; stall drops asynchronously.
//   FSM states and transitions:
//     IDLE -> READ on dbg_start_i.
//     READ -> HOLD always.
//     HOLD -> READ on dump_ready_i when idx != DUMP_COUNT-1.
//     HOLD -> DONE on dump_ready_i when idx == DUMP_COUNT-1.
//     DONE -> IDLE always.
//   cpu_stall_o is registered: high in READ, HOLD and DONE, low in IDLE.
//   The CPU write in the dbg_start_i cycle still commits.
//   IDLE: rf_raddr_o = cpu_raddr_i; rf_we_o/waddr/wdata pass straight through from cpu_*.
//   Not IDLE: rf_raddr_o = idx; rf_we_o forced 0, so a CPU write while stalled is dropped.
//   READ: rf_rdata_i and idx are captured into dump_data_o/dump_addr_o; dump_valid_o is set on the next edge.
//   HOLD: valid, addr and data stay stable until dump_ready_i; on accept idx increments and valid clears.
//   Throughput is 1 word per 2 cycles with ready tied high.
//   Minimum dump latency: start to done = 2*DUMP_COUNT+1 cycles.
//   dbg_start_i outside IDLE is ignored, including in the DONE cycle; it is not queued.
//   dump_ready_i without valid has no effect.
//   idx is a clog2(DUMP_COUNT)-bit counter; a full 2**ADDR_W dump never wraps past the last index.
//   r0 reads whatever the register file returns; no zero forcing here.
// CONFIGURATION
//   DUMP_CSUM_EN defined:
//     adds output dump_csum_o [DATA_W-1:0], cleared on dbg_start_i.
//     Each accepted word is XORed into it; valid in the cycle dump_done_o pulses and held until the next start.
//   Not defined: port and logic absent; behaviour otherwise identical.
// STRUCTURE
//   Package rf_dbg_pkg holds:
//     DATA_W and ADDR_W defaults;
//     the state enum {IDLE, READ, HOLD, DONE} as 2-bit localparams;
//     the helper function cnt_w(n) = clog2 width.
//   Sub-module rf_dump_csum (XOR accumulator: clr, en, din, csum) is instantiated only under DUMP_CSUM_EN.
//   FSM, counter and port muxes are inline.
// TESTING
//   1. Preload r0..r12 = 0,1,..,12; pulse start with ready=1.
//      -> 13 words, addr 0..12, data 0..12; stall high for 27 cycles; done pulses once.
//   2. Ready low for 5 cycles on word 3 (value 3).
//      -> valid/addr/data held stable all 5 cycles; word 4 follows after ready.
//   3. cpu_we_i=1 to r5=99 in the start cycle, and to r6=77 while stalled.
//      -> dump shows r5=99 and r6 unchanged; rf_we_o low throughout the stall.
//   4. Second start pulse at word 7, and one in the DONE cycle.
//      -> ignored; exactly 13 words and one done pulse.
//   5. rst_i at word 6.
//      -> stall, valid and done drop in the same cycle; a new start replays from addr 0.
//   6. DUMP_CSUM_EN with values 0..12.
//      -> dump_csum_o = 0x0000000C at done; without the macro the bench elaborates with no dump_csum_o port.

Source files
------------

// File: rtl/rf_dbg_pkg.sv
// Shared widths, dump FSM state codes and the counter width helper
// for the register file dump sequencer.
package rf_dbg_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // A single-entry dump still needs a 1-bit index register.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_dump_csum.sv
// XOR accumulator over the words accepted during a register dump.
module rf_dump_csum
  import rf_dbg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] csum
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum <= '0;
    end else if (clr) begin
      csum <= '0;
    end else if (en) begin
      csum <= csum ^ din;
    end
  end

endmodule

// File: rtl/rf_dump_sequencer.sv
// Arbitrates the register file ports between the CPU and a debug dump engine
// that streams r0..r(DUMP_COUNT-1). Optional XOR checksum under `DUMP_CSUM_EN.
module rf_dump_sequencer
  import rf_dbg_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DUMP_COUNT = 13
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_raddr_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_waddr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  input  logic              dbg_start_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_done_o
`ifdef DUMP_CSUM_EN
  ,
  output logic [DATA_W-1:0] dump_csum_o
`endif
);

  localparam int IDX_W = cnt_w(DUMP_COUNT);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             idle;
  logic             last;
  logic             accept;

  assign idle   = (state == S_IDLE);
  assign last   = (idx == IDX_W'(DUMP_COUNT - 1));
  assign accept = (state == S_HOLD) && dump_ready_i;

  // The index stops at the last entry instead of wrapping; a new start reloads it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      idx          <= '0;
      cpu_stall_o  <= 1'b0;
      dump_valid_o <= 1'b0;
      dump_done_o  <= 1'b0;
      dump_addr_o  <= '0;
      dump_data_o  <= '0;
    end else begin
      dump_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dbg_start_i) begin
            state       <= S_READ;
            idx         <= '0;
            cpu_stall_o <= 1'b1;
          end
        end
        S_READ: begin
          state        <= S_HOLD;
          dump_valid_o <= 1'b1;
          dump_addr_o  <= ADDR_W'(idx);
          dump_data_o  <= rf_rdata_i;
        end
        S_HOLD: begin
          if (dump_ready_i) begin
            dump_valid_o <= 1'b0;
            if (last) begin
              state       <= S_DONE;
              dump_done_o <= 1'b1;
            end else begin
              state <= S_READ;
              idx   <= idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          cpu_stall_o <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          cpu_stall_o <= 1'b0;
        end
      endcase
    end
  end

  // While stalled the dump engine owns the read port and CPU writes are dropped.
  always_comb begin
    rf_raddr_o = idle ? cpu_raddr_i : ADDR_W'(idx);
    rf_we_o    = idle && cpu_we_i;
    rf_waddr_o = cpu_waddr_i;
    rf_wdata_o = cpu_wdata_i;
  end

`ifdef DUMP_CSUM_EN
  rf_dump_csum #(
    .DATA_W(DATA_W)
  ) u_csum (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr  (idle && dbg_start_i),
    .en   (accept),
    .din  (dump_data_o),
    .csum (dump_csum_o)
  );
`endif

endmodule

// File: tb/tb_rf_dump_sequencer.sv
// Randomized scoreboard bench for rf_dump_sequencer with a register file model
// and a snapshot-based reference of the expected dump stream.
module tb_rf_dump_sequencer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N      = 13;
  localparam int N_REGS = 2 ** ADDR_W;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } word_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] cpu_raddr, cpu_waddr, rf_raddr, rf_waddr, dump_addr;
  logic [DATA_W-1:0] cpu_wdata, rf_rdata, rf_wdata, dump_data;
  logic              cpu_we, stall, rf_we, start, valid, ready, done;
`ifdef DUMP_CSUM_EN
  logic [DATA_W-1:0] dump_csum;
`endif

  logic [DATA_W-1:0] rfMem  [N_REGS];
  logic [DATA_W-1:0] shadow [N_REGS];
  word_t             expQ[$];
  logic [DATA_W-1:0] csumExp;
  bit                modelBusy = 0;
  int                doneCount = 0;
  int                errors = 0;
  int                checks = 0;

  always #5 clk = ~clk;

  rf_dump_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DUMP_COUNT(N)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_raddr_i(cpu_raddr), .cpu_we_i(cpu_we), .cpu_waddr_i(cpu_waddr), .cpu_wdata_i(cpu_wdata),
    .cpu_stall_o(stall),
    .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .dbg_start_i(start),
    .dump_valid_o(valid), .dump_ready_i(ready),
    .dump_addr_o(dump_addr), .dump_data_o(dump_data),
    .dump_done_o(done)
`ifdef DUMP_CSUM_EN
    , .dump_csum_o(dump_csum)
`endif
  );

  // Register file: combinational read, write on the rising edge.
  assign rf_rdata = rfMem[rf_raddr];
  always @(posedge clk) if (rf_we) rfMem[rf_waddr] = rf_wdata;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input bit randomData);
    for (int i = 0; i < N_REGS; i++) begin
      logic [DATA_W-1:0] v;
      v = randomData ? DATA_W'($urandom) : DATA_W'(i);
      rfMem[i]  = v;
      shadow[i] = v;
    end
  endtask

  // One cycle of CPU/debug stimulus; the model commits idle writes and snapshots on an accepted start.
  task automatic applyStimulus(input logic s, input logic we, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd);
    start     = s;
    cpu_we    = we;
    cpu_waddr = wa;
    cpu_wdata = wd;
    cpu_raddr = ADDR_W'($urandom);
    if (we && !modelBusy) shadow[wa] = wd;
    if (s && !modelBusy) begin
      modelBusy = 1;
      csumExp   = '0;
      for (int i = 0; i < N; i++) begin
        expQ.push_back(word_t'{ADDR_W'(i), shadow[i]});
        csumExp ^= shadow[i];
      end
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    cpu_we = 1'b0;
  endtask

  task automatic waitDone(input int limit, input bit rndReady);
    int c = 0;
    while (modelBusy && c < limit) begin
      ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      c++;
    end
    ready = 1'b1;
    checkOutput("dump_finished", 64'(modelBusy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted word and checks stall/hold/done rules.
  logic              holdPending = 0;
  logic [ADDR_W-1:0] holdA;
  logic [DATA_W-1:0] holdD;
  logic              prevDone = 0;
  int                stallCnt = 0;
  int                waitCnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      holdPending = 0;
      prevDone    = 0;
      stallCnt    = 0;
      waitCnt     = 0;
    end else begin
      if (stall) begin
        stallCnt++;
        checkOutput("rf_we_gated", 64'(rf_we), 64'd0);
      end
      if (prevDone) begin
        checkOutput("stall_release", 64'(stall), 64'd0);
        checkOutput("done_one_cycle", 64'(done), 64'd0);
      end
      if (holdPending) begin
        checkOutput("hold_valid", 64'(valid), 64'd1);
        checkOutput("hold_addr", 64'(dump_addr), 64'(holdA));
        checkOutput("hold_data", 64'(dump_data), 64'(holdD));
      end
      holdPending = 0;
      if (valid) begin
        if (ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_word", 64'd1, 64'd0);
          end else begin
            word_t w;
            w = expQ.pop_front();
            checkOutput("dump_addr", 64'(dump_addr), 64'(w.a));
            checkOutput("dump_data", 64'(dump_data), 64'(w.d));
          end
        end else begin
          waitCnt++;
          holdPending = 1;
          holdA = dump_addr;
          holdD = dump_data;
        end
      end
      if (done) begin
        checkOutput("done_expected", 64'(modelBusy), 64'd1);
        checkOutput("words_left_at_done", 64'(expQ.size()), 64'd0);
        checkOutput("stall_cycles", 64'(stallCnt), 64'(2 * N + 1 + waitCnt));
`ifdef DUMP_CSUM_EN
        checkOutput("csum_at_done", 64'(dump_csum), 64'(csumExp));
`endif
        modelBusy = 0;
        doneCount++;
      end
      prevDone = done;
      if (!stall) begin
        stallCnt = 0;
        waitCnt  = 0;
      end
    end
  end

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; ready = 1'b1; cpu_we = 1'b0;
    cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = '0;
    preload(0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_stall", 64'(stall), 64'd0);
    checkOutput("reset_valid", 64'(valid), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_addr", 64'(dump_addr), 64'd0);
    checkOutput("reset_data", 64'(dump_data), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] basic dump of 0..12");
    applyStimulus(1, 0, '0, '0);
    waitDone(200, 0);
    checkOutput("done_count_basic", 64'(doneCount), 64'd1);
`ifdef DUMP_CSUM_EN
    checkOutput("csum_0_to_12", 64'(dump_csum), 64'h0000_000C);
`endif

    $display("[TB] backpressure on word 3");
    applyStimulus(1, 0, '0, '0);
    repeat (7) @(posedge clk);
    #1;
    ready = 1'b0;
    checkOutput("bp_word_addr", 64'(dump_addr), 64'd3);
    checkOutput("bp_word_valid", 64'(valid), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bp_held_addr", 64'(dump_addr), 64'd3);
    ready = 1'b1;
    waitDone(200, 0);

    $display("[TB] writes in start cycle and while stalled");
    applyStimulus(1, 1, ADDR_W'(5), 32'd99);
    applyStimulus(0, 1, ADDR_W'(6), 32'd77);
    waitDone(200, 0);
    checkOutput("r6_untouched", 64'(rfMem[6]), 64'd6);

    $display("[TB] ignored starts mid-dump and in DONE");
    dc = doneCount;
    applyStimulus(1, 0, '0, '0);
    repeat (14) @(posedge clk);
    #1;
    applyStimulus(1, 0, '0, '0);
    repeat (11) @(posedge clk);
    #1;
    checkOutput("done_latency", 64'(done), 64'd1);
    applyStimulus(1, 0, '0, '0);
    waitDone(200, 0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("single_done", 64'(doneCount - dc), 64'd1);
    checkOutput("no_queued_start", 64'(stall), 64'd0);

    $display("[TB] reset at word 6");
    preload(0);
    dc = doneCount;
    applyStimulus(1, 0, '0, '0);
    repeat (13) @(posedge clk);
    #1;
    checkOutput("pre_reset_addr", 64'(dump_addr), 64'd6);
    rst = 1'b1;
    expQ.delete();
    modelBusy = 0;
    #1;
    checkOutput("abort_stall", 64'(stall), 64'd0);
    checkOutput("abort_valid", 64'(valid), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, '0, '0);
    waitDone(200, 0);
    checkOutput("replay_done", 64'(doneCount - dc), 64'd1);

    $display("[TB] randomized dumps");
    preload(1);
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 4; w++)
        applyStimulus(0, 1, ADDR_W'($urandom_range(0, N - 1)), DATA_W'($urandom));
      applyStimulus(1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, N - 1)), DATA_W'($urandom));
      for (int w = 0; w < 2; w++)
        applyStimulus(0, 1, ADDR_W'($urandom_range(0, N - 1)), DATA_W'($urandom));
      waitDone(400, 1);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
